// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_pkg
//  Description : Shared FSM state type and parameter defaults for the
//                PWM clock-divider change controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

   // Default number of cycles the divider is held in reset during a change
   localparam int unsigned c_hold_cyc_default = 2;

   // Default number of cycles to wait for a low divided-clock phase
   localparam int unsigned c_timeout_default  = 131072;

   // Controller states
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RUN      = 3'd1,
      WAIT_LOW = 3'd2,
      HOLD     = 3'd3,
      RELEASE  = 3'd4
   } pwm_state_e;

endpackage : pwm_pkg
`default_nettype wire

// File: rtl/pwm_div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_div_ctrl
//  Description : Safely changes the divisor of a neighbouring clock divider.
//                While the divider runs, a new divisor is applied only after
//                the divided clock is seen low (or a timeout expires), with
//                the divider held in reset for HOLD_CYC cycles around the
//                update so no runt pulse is produced.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_div_ctrl
   import pwm_pkg::*;
#(
   parameter int unsigned HOLD_CYC = c_hold_cyc_default,
   parameter int unsigned TIMEOUT  = c_timeout_default
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        en_i,
   input  logic        req_valid_i,
   input  logic [15:0] req_divisor_i,
   output logic        req_ready_o,
   input  logic        div_clk_i,
   output logic        div_rst_no,
   output logic [15:0] divisor_o,
   output logic        busy_o,
   output logic        applied_o,
   output logic        timeout_o
);

   localparam int unsigned c_tcnt_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [c_tcnt_w-1:0] c_tcnt_last = c_tcnt_w'(TIMEOUT - 1);
   localparam logic [c_tcnt_w-1:0] c_tcnt_one  = c_tcnt_w'(1);
   localparam logic [3:0]          c_hcnt_last = 4'(HOLD_CYC - 1);

   pwm_state_e          state_q;
   logic [15:0]         pending_q;
   logic [15:0]         divisor_q;
   logic                div_rst_n_q;
   logic                busy_q;
   logic                applied_q;
   logic                timeout_q;
   logic [c_tcnt_w-1:0] tcnt_q;
   logic [3:0]          hcnt_q;

   logic                w_accept;
   logic                w_safe;

   // Requests are only taken while the divider is idle or steadily running
   assign req_ready_o = (state_q == IDLE) || (state_q == RUN);
   assign w_accept    = req_valid_i && req_ready_o;

   // The divided clock is generated from clk_i by the divider, so it is
   // already synchronous and is sampled directly. A bypass divisor has no
   // low phase to wait for; dropping en_i also abandons the wait.
   assign w_safe = !en_i || !div_clk_i || (divisor_q == 16'd0);

   // Controller FSM with all outputs registered
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         pending_q   <= 16'd0;
         divisor_q   <= 16'd0;
         div_rst_n_q <= 1'b0;
         busy_q      <= 1'b0;
         applied_q   <= 1'b0;
         timeout_q   <= 1'b0;
         tcnt_q      <= '0;
         hcnt_q      <= 4'd0;
      end else begin
         applied_q <= 1'b0;
         timeout_q <= 1'b0;
         case (state_q)
            IDLE: begin
               // Divider is already in reset: apply immediately
               if (w_accept) begin
                  pending_q <= req_divisor_i;
                  divisor_q <= req_divisor_i;
                  applied_q <= 1'b1;
               end
               if (en_i) begin
                  state_q     <= RUN;
                  div_rst_n_q <= 1'b1;
               end
            end
            RUN: begin
               if (w_accept) begin
                  pending_q <= req_divisor_i;
                  state_q   <= WAIT_LOW;
                  busy_q    <= 1'b1;
                  tcnt_q    <= '0;
               end else if (!en_i) begin
                  state_q     <= IDLE;
                  div_rst_n_q <= 1'b0;
               end
            end
            WAIT_LOW: begin
               if (w_safe || (tcnt_q == c_tcnt_last)) begin
                  state_q     <= HOLD;
                  div_rst_n_q <= 1'b0;
                  divisor_q   <= pending_q;
                  hcnt_q      <= 4'd0;
                  timeout_q   <= !w_safe;
               end else if (tcnt_q != '1) begin
                  tcnt_q <= tcnt_q + c_tcnt_one;
               end
            end
            HOLD: begin
               if (hcnt_q == c_hcnt_last) begin
                  state_q     <= RELEASE;
                  div_rst_n_q <= 1'b1;
                  applied_q   <= 1'b1;
               end else begin
                  hcnt_q <= hcnt_q + 4'd1;
               end
            end
            RELEASE: begin
               busy_q <= 1'b0;
               if (en_i) begin
                  state_q <= RUN;
               end else begin
                  state_q     <= IDLE;
                  div_rst_n_q <= 1'b0;
               end
            end
            default: begin
               state_q     <= IDLE;
               div_rst_n_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign div_rst_no = div_rst_n_q;
   assign divisor_o  = divisor_q;
   assign busy_o     = busy_q;
   assign applied_o  = applied_q;
   assign timeout_o  = timeout_q;

endmodule : pwm_div_ctrl
`default_nettype wire

// File: tb/tb_pwm_div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_div_ctrl
//  Description : Self-checking bench for pwm_div_ctrl. Expected output
//                timelines of each divisor change are derived arithmetically
//                from the divided-clock pattern the bench drives.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_div_ctrl;

   localparam int HOLD = 2;
   localparam int TMO  = 16;
   localparam int NO_DROP = 100000;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        en_i;
   logic        req_valid_i;
   logic [15:0] req_divisor_i;
   logic        req_ready_o;
   logic        div_clk_i;
   logic        div_rst_no;
   logic [15:0] divisor_o;
   logic        busy_o;
   logic        applied_o;
   logic        timeout_o;

   int          n_vec = 0;
   int          n_err = 0;

   // Reference view of the controller at transaction level
   logic [15:0] model_div;
   bit          model_run;

   pwm_div_ctrl #(
      .HOLD_CYC (HOLD),
      .TIMEOUT  (TMO)
   ) u_dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .en_i          (en_i),
      .req_valid_i   (req_valid_i),
      .req_divisor_i (req_divisor_i),
      .req_ready_o   (req_ready_o),
      .div_clk_i     (div_clk_i),
      .div_rst_no    (div_rst_no),
      .divisor_o     (divisor_o),
      .busy_o        (busy_o),
      .applied_o     (applied_o),
      .timeout_o     (timeout_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic chk_out(input string tag, input bit rdy, input bit rst_n, input bit busy,
                          input bit app, input bit tmo, input logic [15:0] div);
      chk({tag, ".ready"},   32'(req_ready_o), 32'(rdy));
      chk({tag, ".div_rst"}, 32'(div_rst_no),  32'(rst_n));
      chk({tag, ".busy"},    32'(busy_o),      32'(busy));
      chk({tag, ".applied"}, 32'(applied_o),   32'(app));
      chk({tag, ".timeout"}, 32'(timeout_o),   32'(tmo));
      chk({tag, ".divisor"}, 32'(divisor_o),   32'(div));
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic [15:0] rand_div();
      return ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
   endfunction

   // Accept a divisor while idle, optionally enabling in the same cycle
   task automatic idle_accept(input logic [15:0] d, input bit with_en);
      en_i          = with_en;
      req_valid_i   = 1'b1;
      req_divisor_i = d;
      chk("idle.ready", 32'(req_ready_o), 32'd1);
      step();
      req_valid_i   = 1'b0;
      req_divisor_i = 16'($urandom);
      chk_out("idle_acc", 1'b1, with_en, 1'b0, 1'b1, 1'b0, d);
      model_div = d;
      model_run = with_en;
      step();
      chk_out("idle_after", 1'b1, with_en, 1'b0, 1'b0, 1'b0, d);
   endtask

   task automatic set_en(input bit e);
      en_i = e;
      step();
      chk_out("set_en", 1'b1, e, 1'b0, 1'b0, 1'b0, model_div);
      model_run = e;
   endtask

   // Divisor change from RUN. mode: 0 div_clk stuck high, 1 mostly high,
   // 2 random, 3 high for three cycles then low. en_i drops from WAIT_LOW
   // cycle drop_at onwards. With queue_next, a follow-up request is held
   // valid during the whole change.
   task automatic do_change(input logic [15:0] d, input int mode, input int drop_at,
                            input bit queue_next, input logic [15:0] d_next);
      bit p [TMO];
      int w;
      bit forced;
      bit en_end;
      for (int k = 0; k < TMO; k++) begin
         case (mode)
            0:       p[k] = 1'b1;
            1:       p[k] = ($urandom_range(0, 5) != 0);
            2:       p[k] = 1'($urandom_range(0, 1));
            default: p[k] = (k < 3);
         endcase
      end
      // Length of the wait: first safe cycle, else the full timeout
      w = 0;
      forced = 1'b0;
      for (int k = 0; k < TMO; k++) begin
         if (!p[k] || model_div == 16'd0 || k >= drop_at) begin
            w = k + 1;
            break;
         end
      end
      if (w == 0) begin
         w = TMO;
         forced = 1'b1;
      end
      en_end = (w + HOLD) < drop_at;

      req_valid_i   = 1'b1;
      req_divisor_i = d;
      chk("run.ready", 32'(req_ready_o), 32'd1);
      step();
      req_valid_i   = queue_next;
      req_divisor_i = queue_next ? d_next : 16'($urandom);
      en_i          = (0 < drop_at);
      div_clk_i     = p[0];
      for (int j = 1; j <= w + HOLD + 1; j++) begin
         step();
         chk_out($sformatf("chg%0d", j),
                 (j == w + HOLD + 1),
                 (j < w) ? 1'b1 : (j < w + HOLD) ? 1'b0 : (j == w + HOLD) ? 1'b1 : en_end,
                 (j <= w + HOLD),
                 (j == w + HOLD),
                 forced && (j == w),
                 (j < w) ? model_div : d);
         en_i      = (j < drop_at);
         div_clk_i = (j < TMO) ? p[j] : 1'($urandom_range(0, 1));
      end
      en_i      = en_end;
      model_div = d;
      model_run = en_end;
   endtask

   initial begin
      rst_ni        = 1'b0;
      en_i          = 1'b0;
      req_valid_i   = 1'b0;
      req_divisor_i = 16'd0;
      div_clk_i     = 1'b1;
      model_div     = 16'd0;
      model_run     = 1'b0;

      // Reset values, then first cycle after release
      #12;
      chk_out("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
      step();
      rst_ni = 1'b1;
      chk("post_rst.ready", 32'(req_ready_o), 32'd1);
      step();
      chk_out("post_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);

      // Idle accept of 4, divider stays in reset
      idle_accept(16'd4, 1'b0);
      set_en(1'b1);

      // Change to 10, divided clock low after three cycles
      do_change(16'd10, 3, NO_DROP, 1'b0, 16'd0);

      // Divided clock stuck high: forced by timeout
      do_change(16'd7, 0, NO_DROP, 1'b0, 16'd0);

      // Request held during a change is taken in the first RUN cycle after
      do_change(16'd21, 1, NO_DROP, 1'b1, 16'd300);
      do_change(16'd300, 2, NO_DROP, 1'b0, 16'd0);

      // Same divisor again still runs the full sequence
      do_change(16'd300, 0, NO_DROP, 1'b0, 16'd0);

      // en_i dropped while waiting: completes the change, ends idle
      do_change(16'd55, 0, 2, 1'b0, 16'd0);

      // Bypass divisor, then enable together with a request
      idle_accept(16'd0, 1'b0);
      idle_accept(16'd9, 1'b1);

      // Randomized operation mix
      for (int it = 0; it < 40; it++) begin
         if (!model_run) begin
            if ($urandom_range(0, 2) == 0) set_en(1'b1);
            else idle_accept(rand_div(), 1'($urandom_range(0, 1)));
         end else begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 2) begin
               set_en(1'b0);
            end else if (sel < 4) begin
               logic [15:0] dn;
               dn = rand_div();
               do_change(rand_div(), $urandom_range(0, 3), NO_DROP, 1'b1, dn);
               do_change(dn, $urandom_range(0, 3), NO_DROP, 1'b0, 16'd0);
            end else begin
               do_change(rand_div(), $urandom_range(0, 3),
                         ($urandom_range(0, 3) == 0) ? $urandom_range(0, TMO + 3) : NO_DROP,
                         1'b0, 16'd0);
            end
         end
      end

      // Asynchronous reset while in HOLD
      if (!model_run) idle_accept(16'd5, 1'b1);
      if (model_div == 16'd0) begin
         set_en(1'b0);
         idle_accept(16'd5, 1'b1);
      end
      req_valid_i   = 1'b1;
      req_divisor_i = 16'd77;
      step();
      req_valid_i = 1'b0;
      div_clk_i   = 1'b0;
      step();
      chk("hold.div_rst", 32'(div_rst_no), 32'd0);
      chk("hold.divisor", 32'(divisor_o), 32'd77);
      #2;
      rst_ni = 1'b0;
      #1;
      chk_out("async_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
      en_i = 1'b0;
      #1;
      rst_ni = 1'b1;
      step();
      chk_out("after_async", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_pwm_div_ctrl
`default_nettype wire
